// File: rtl/vector_reg_file.sv
// vector_reg_file: NUM_VREGS x MAX_VL x DATA_W vector register file.
// Two combinational read ports; one streaming write port that fills a
// staging buffer element by element and commits it to the destination
// register in a single COMMIT cycle (tail-undisturbed).
// Optional feature macro: VRF_BYPASS_EN -- forwards staging data to a read
// port addressing the destination register during the COMMIT cycle.

`ifdef VRF_BYPASS_EN
// Per-element read mux: picks staged data over array data when bypassing.
module vrf_rd_lane #(
    parameter int DATA_W = 32
) (
    input  logic              byp,
    input  logic [DATA_W-1:0] arr_elem,
    input  logic [DATA_W-1:0] stg_elem,
    output logic [DATA_W-1:0] rd_elem
);
    assign rd_elem = byp ? stg_elem : arr_elem;
endmodule
`endif

module vector_reg_file #(
    parameter int DATA_W    = 32,
    parameter int NUM_VREGS = 8,
    parameter int MAX_VL    = 8,
    parameter int ADDR_W    = $clog2(NUM_VREGS),
    parameter int VL_W      = $clog2(MAX_VL + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_start,
    input  logic [ADDR_W-1:0]        wr_vd,
    input  logic [VL_W-1:0]          wr_vl,
    input  logic                     wr_valid,
    input  logic [DATA_W-1:0]        wr_data,
    output logic                     wr_ready,
    input  logic                     wr_abort,
    output logic                     busy,
    output logic                     done,
    input  logic [ADDR_W-1:0]        rd_vs1,
    input  logic [ADDR_W-1:0]        rd_vs2,
    output logic [MAX_VL*DATA_W-1:0] rd_v1_data,
    output logic [MAX_VL*DATA_W-1:0] rd_v2_data
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    localparam logic [VL_W-1:0] MAX_VL_V = VL_W'(MAX_VL);
    localparam logic [VL_W-1:0] ONE_V    = VL_W'(1);

    state_t                                        state_q, state_d;
    logic [ADDR_W-1:0]                             vd_q, vd_d;
    logic [VL_W-1:0]                               vl_q, vl_d;
    logic [VL_W-1:0]                               count_q, count_d;
    logic [MAX_VL-1:0][DATA_W-1:0]                 staging_q, staging_d;
    logic [NUM_VREGS-1:0][MAX_VL-1:0][DATA_W-1:0]  vregs_q, vregs_d;

    logic [VL_W-1:0] eff_vl;

    // Clamp the requested length to the register capacity.
    always_comb begin
        eff_vl = (wr_vl > MAX_VL_V) ? MAX_VL_V : wr_vl;
    end

    // Next-state, staging fill and commit merge.
    always_comb begin
        state_d   = state_q;
        vd_d      = vd_q;
        vl_d      = vl_q;
        count_d   = count_q;
        staging_d = staging_q;
        vregs_d   = vregs_q;
        wr_ready  = 1'b0;
        done      = 1'b0;
        case (state_q)
            IDLE: begin
                if (wr_start) begin
                    vd_d    = wr_vd;
                    vl_d    = eff_vl;
                    count_d = '0;
                    state_d = (eff_vl == '0) ? COMMIT : FILL;
                end
            end
            FILL: begin
                wr_ready = 1'b1;
                // Abort takes priority over a coincident final accept.
                if (wr_abort) begin
                    state_d = IDLE;
                end else if (wr_valid) begin
                    for (int i = 0; i < MAX_VL; i++) begin
                        if (VL_W'(i) == count_q) staging_d[i] = wr_data;
                    end
                    count_d = count_q + ONE_V;
                    if (count_q == vl_q - ONE_V) state_d = COMMIT;
                end
            end
            COMMIT: begin
                done = 1'b1;
                for (int i = 0; i < MAX_VL; i++) begin
                    if (VL_W'(i) < vl_q) vregs_d[vd_q][i] = staging_q[i];
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and storage registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            vd_q      <= '0;
            vl_q      <= '0;
            count_q   <= '0;
            staging_q <= '0;
            vregs_q   <= '0;
        end else begin
            state_q   <= state_d;
            vd_q      <= vd_d;
            vl_q      <= vl_d;
            count_q   <= count_d;
            staging_q <= staging_d;
            vregs_q   <= vregs_d;
        end
    end

    assign busy = (state_q != IDLE);

`ifdef VRF_BYPASS_EN
    logic hit1, hit2;
    assign hit1 = (state_q == COMMIT) && (rd_vs1 == vd_q);
    assign hit2 = (state_q == COMMIT) && (rd_vs2 == vd_q);

    // Per-element forwarding of staged data while the commit is in flight.
    for (genvar i = 0; i < MAX_VL; i++) begin : g_byp
        localparam logic [VL_W-1:0] IDX = VL_W'(i);
        vrf_rd_lane #(.DATA_W(DATA_W)) u_rd1 (
            .byp      (hit1 && (IDX < vl_q)),
            .arr_elem (vregs_q[rd_vs1][i]),
            .stg_elem (staging_q[i]),
            .rd_elem  (rd_v1_data[i*DATA_W +: DATA_W])
        );
        vrf_rd_lane #(.DATA_W(DATA_W)) u_rd2 (
            .byp      (hit2 && (IDX < vl_q)),
            .arr_elem (vregs_q[rd_vs2][i]),
            .stg_elem (staging_q[i]),
            .rd_elem  (rd_v2_data[i*DATA_W +: DATA_W])
        );
    end
`else
    assign rd_v1_data = vregs_q[rd_vs1];
    assign rd_v2_data = vregs_q[rd_vs2];
`endif

endmodule

// File: doc/vector_reg_file.md
# vector_reg_file

Parametrised vector register file for the vector processing unit: NUM_VREGS architectural vector registers, each holding MAX_VL elements of DATA_W bits. Two combinational read ports feed the vector lanes. One streaming write port accepts one element per cycle through a valid/ready handshake into a staging buffer, then commits all elements atomically to the destination register. It sits between the lane/load result path and the vector execution lanes, and replaces the fixed 8x8x32 register block.

## Interface
Parameters:
- DATA_W, 32, element width in bits
- NUM_VREGS, 8, number of vector registers (power of two, >=2)
- MAX_VL, 8, elements per register (>=1)
- ADDR_W, $clog2(NUM_VREGS), register index width (derived)
- VL_W, $clog2(MAX_VL+1), vector-length field width (derived)

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, asynchronous, active-high
- wr_start  in  1  start-of-write pulse; sampled only in IDLE
- wr_vd  in  ADDR_W  destination register; latched on accepted wr_start
- wr_vl  in  VL_W  element count; latched on accepted wr_start
- wr_valid  in  1  element valid
- wr_data  in  DATA_W  element data
- wr_ready  out  1  element accept; high only in FILL
- wr_abort  in  1  discard the in-flight write
- busy  out  1  state != IDLE
- done  out  1  one-cycle commit strobe
- rd_vs1, rd_vs2  in  ADDR_W  read register indices
- rd_v1_data, rd_v2_data  out  MAX_VL*DATA_W  full register contents; element i is at bits [i*DATA_W +: DATA_W]

## Operation
- FSM states: IDLE, FILL, COMMIT.
- IDLE: on wr_start, latch wr_vd and eff_vl = min(wr_vl, MAX_VL), clear the element counter, then:
  - go to FILL if eff_vl > 0;
  - go to COMMIT if eff_vl == 0 (nothing is written, done still pulses).
- FILL: wr_ready=1. Each wr_valid&&wr_ready cycle writes wr_data to staging[count] and increments count. Accepting element eff_vl-1 moves the FSM to COMMIT.
- COMMIT (exactly one cycle): done=1. At the closing edge, elements 0..eff_vl-1 of VRegs[vd] take the staging values. Elements eff_vl..MAX_VL-1 keep their old values (tail-undisturbed). The FSM then returns to IDLE.
- wr_abort in FILL: return to IDLE next edge; the array is unchanged and done stays 0. If abort coincides with the final accept, abort wins. wr_abort is ignored in IDLE and COMMIT.
- wr_start outside IDLE is ignored (no queuing).
- Staging buffer and counter reset to 0. The staging buffer is not cleared between writes; only elements below eff_vl are ever committed.
- Reads are purely combinational from the array (see Configuration). rd_vs1 == rd_vs2 is legal.
- Reset values, applied asynchronously:
  - all VRegs elements = 0
  - state = IDLE, count = 0
  - done = 0, wr_ready = 0, busy = 0
  - read outputs = 0 (array is zeroed)
- rst asserted mid-FILL or mid-COMMIT: the write is lost and the array is zeroed.

## Timing
- wr_start accepted at edge 0: wr_ready is high from cycle 1.
- With wr_valid held high, elements are accepted in cycles 1..eff_vl, done is high in cycle eff_vl+1, and busy falls in cycle eff_vl+2.
- Gaps in wr_valid extend FILL one cycle per idle cycle.
- Earliest next wr_start acceptance is the cycle after COMMIT.
- eff_vl == 0: done is high in cycle 1.
- Read latency is 0 cycles from rd_vs change to rd_v*_data change.

## Configuration
- VRF_BYPASS_EN defined:
  - during COMMIT, a read port whose index equals the latched vd returns staging values for elements < eff_vl and array values for the rest, so the data is visible in the done cycle;
  - adds MAX_VL*2 DATA_W muxes.
- VRF_BYPASS_EN undefined: reads return the pre-commit contents during COMMIT; new data appears from the cycle after done.

## Test plan
- Full write: rst, wr_start vd=3 vl=8, eight elements 0x10..0x17 back-to-back.
  -> done is high exactly in cycle 9.
  -> from cycle 10, rd_vs1=3 gives elements 0x10..0x17 and all other registers read 0.
- Partial write and clamp:
  - preload v5 with 0xA0..0xA7, then wr_start vd=5 vl=3 with data 1,2,3 -> v5 = 1,2,3,0xA3..0xA7.
  - wr_vl=12 with MAX_VL=8 -> exactly 8 accepts, then done.
- Abort and zero-length:
  - wr_abort in the cycle of the 4th accept of a vl=8 write -> no done, target register unchanged, busy low next cycle, wr_start accepted after.
  - wr_start vl=0 -> done in cycle 1 and the array is unchanged.
- Handshake stalls: wr_valid pattern 1,0,0,1,1 for vl=3 -> done in cycle 6; wr_start pulsed during FILL is ignored.
- Bypass: read rd_vs2=vd during COMMIT.
  -> with VRF_BYPASS_EN, returns new data;
  -> without it, returns old data, then new data one cycle later.
- Async reset mid-FILL: rst pulsed between clock edges -> wr_ready, busy and done drop immediately, all reads return 0, and a new write works normally.
